mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one data/instruction memory bus master port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access as a stb/ack bus cycle and returns read data with a one-cycle done pulse.
- Raises per-stage stall requests toward the pipeline controller while an access is pending.
- Sits between the IF/MEM stages and the external SRAM/bus bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; bus_sel is DATA_W/8 bits.
- TIMEOUT, 255, max wait cycles for ack; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- inst_req_i  in  1  IF access request; held until inst_done_o.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_rdata_o  out  DATA_W  fetched word (registered).
- inst_done_o  out  1  one-cycle completion pulse.
- stallreq_if_o  out  1  IF stall request.
- data_req_i  in  1  MEM access request; held with payload until data_done_o.
- data_we_i  in  1  1 = store, 0 = load.
- data_sel_i  in  DATA_W/8  byte enables.
- data_addr_i  in  ADDR_W  load/store address.
- data_wdata_i  in  DATA_W  store data.
- data_rdata_o  out  DATA_W  load data (registered).
- data_done_o  out  1  one-cycle completion pulse.
- stallreq_mem_o  out  1  MEM stall request.
- flush_i  in  1  pipeline flush; affects instruction side only.
- bus_stb_o  out  1  bus cycle valid.
- bus_we_o  out  1  bus write.
- bus_sel_o  out  DATA_W/8  bus byte enables.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_ack_i  in  1  bus completion; rdata is valid in the same cycle.
- bus_rdata_i  in  DATA_W  bus read data.
- err_o  out  1  timeout pulse; tied 0 without the optional feature.

Behaviour:
- Reset:
  - Every output register clears to 0: bus_*, *_rdata_o, *_done_o, err_o.
  - State goes to IDLE; the discard flag clears.
  - A reset mid-cycle abandons the transaction. Any later stray bus_ack_i is ignored.
- States: IDLE, DATA, INST.
- IDLE:
  - A requester whose done_o is high this cycle is not eligible (its request is stale).
  - If data_req_i is eligible: go to DATA. Register addr/we/sel/wdata onto bus_*, with bus_stb_o = 1 from the next cycle.
  - Else if inst_req_i is eligible and flush_i = 0: go to INST with we = 0 and sel = all ones.
  - Data always wins a simultaneous request.
- DATA / INST:
  - bus_* held stable until bus_ack_i.
  - On ack: drop bus_stb_o at the next edge and return to IDLE.
  - Reads capture bus_rdata_i into the matching *_rdata_o. A store leaves data_rdata_o unchanged.
  - done_o pulses for exactly the cycle after ack.
  - bus_ack_i in IDLE is ignored.
- Latency and throughput:
  - Request seen at edge 0 → stb high in cycle 1 → ack in cycle k ≥ 1 → done in cycle k+1.
  - At least one IDLE cycle separates transactions.
- Stall requests (combinational):
  - stallreq_mem_o = data_req_i & ~data_done_o.
  - stallreq_if_o = inst_req_i & ~inst_done_o & ~flush_i.
- Flush:
  - In INST, flush_i sets the discard flag. The bus cycle still completes, but there is no inst_done_o pulse and inst_rdata_o is not updated.
  - flush_i in DATA has no effect; a store in MEM always completes.
  - The discard flag clears on return to IDLE.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- With the macro defined:
  - A counter counts cycles with bus_stb_o = 1 and no ack.
  - When the count reaches TIMEOUT, the cycle ends as if acked: rdata written as 0 (loads/fetches), done pulse (unless discarded), err_o pulses in the same cycle as done.
  - The counter clears in IDLE.
- Without the macro: the block waits for ack indefinitely, no counter is built, and err_o is tied 0.

Decomposition:
- Shared defines/package holds:
  - state encodings ARB_IDLE / ARB_DATA / ARB_INST;
  - ZeroWord;
  - RegBus width;
  - WriteEnable/WriteDisable;
  - the all-ones byte-select constant.
- One natural sub-module, bus_timeout_cnt (counter plus compare), instantiated only under MEM_BUS_TIMEOUT_EN.

Test Plan:
- Data load: data_req_i=1, we=0, addr=0x100, ack 3 cycles after stb with rdata=0xDEADBEEF → data_done_o pulses 1 cycle, data_rdata_o=0xDEADBEEF, stallreq_mem_o low in the done cycle.
- Simultaneous requests: inst_req_i=1 (addr 0x40) and data store (addr 0x200, wdata 0x12345678, sel 0xF) in the same cycle → bus shows 0x200/we=1 first; fetch of 0x40 starts after one IDLE cycle.
- Stale request: requester holds req high during its done cycle → no second bus cycle launched.
- Flush during fetch: flush_i=1 while INST outstanding, ack rdata=0xAAAA5555 → no inst_done_o, inst_rdata_o unchanged, state returns to IDLE.
- Reset mid-cycle: rst while stb high, then ack arrives → all outputs 0, no done pulse.
- MEM_BUS_TIMEOUT_EN with TIMEOUT=4, load and no ack → done and err_o pulse together 4 cycles after stb, data_rdata_o=0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared types and constants for the IF/MEM memory bus arbiter:
//               arbiter state encodings, bus word width, write-enable levels,
//               and the zero word / all-ones byte-select constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  // Arbiter states: idle, serving MEM (load/store), serving IF (fetch)
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DATA = 2'd1,
    ARB_INST = 2'd2
  } arb_state_t;

  // Native register/bus word width
  localparam int c_REG_BUS_W = 32;

  // Zero word; cast to the instance data width at the point of use
  localparam logic [c_REG_BUS_W-1:0] c_ZERO_WORD = '0;

  // Bus write direction levels
  localparam logic c_WRITE_ENABLE  = 1'b1;
  localparam logic c_WRITE_DISABLE = 1'b0;

  // All-ones byte select, wide enough to be truncated to any DATA_W/8 up to 64
  localparam logic [63:0] c_SEL_ALL_ONES = '1;

endpackage : mem_bus_arbiter_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter_bus_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_cnt
// Description : Counts cycles a bus strobe is held without acknowledge and
//               flags the cycle in which the TIMEOUT-th unacknowledged cycle
//               occurs, so the arbiter can terminate the bus cycle at the
//               next edge. Only instantiated when MEM_BUS_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  input  logic ack_i,
  output logic hit_o
);

  localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [c_CNT_W-1:0] r_cnt;

  // This is the TIMEOUT-th strobed cycle with no acknowledge
  assign hit_o = stb_i & ~ack_i & (r_cnt == c_CNT_W'(TIMEOUT - 1));

  // Wait-cycle counter; cleared whenever no bus cycle is waiting
  always_ff @(posedge clk) begin
    if (rst || !stb_i || ack_i || hit_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

endmodule : bus_timeout_cnt
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares a single memory bus master port between the IF stage
//               (instruction fetch) and the MEM stage (load/store). Each
//               access runs as one stb/ack bus cycle; read data is registered
//               and accompanied by a one-cycle done pulse. MEM always wins a
//               simultaneous request. A flush during a fetch lets the bus
//               cycle finish but discards its result.
//               Optional macro MEM_BUS_TIMEOUT_EN adds an ack timeout that
//               ends a stuck bus cycle with zero data and an err_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = c_REG_BUS_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // IF stage
  input  logic                inst_req_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_rdata_o,
  output logic                inst_done_o,
  output logic                stallreq_if_o,
  // MEM stage
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_sel_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_done_o,
  output logic                stallreq_mem_o,
  // Pipeline flush (instruction side only)
  input  logic                flush_i,
  // Bus master port
  output logic                bus_stb_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                err_o
);

  localparam int c_SEL_W = DATA_W / 8;

  // Registered state
  arb_state_t          r_state;
  logic                r_discard;
  logic                r_bus_stb;
  logic                r_bus_we;
  logic [c_SEL_W-1:0]  r_bus_sel;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic                r_inst_done;
  logic [DATA_W-1:0]   r_data_rdata;
  logic                r_data_done;

  // Next-state values
  arb_state_t          w_state_nxt;
  logic                w_discard_nxt;
  logic                w_bus_stb_nxt;
  logic                w_bus_we_nxt;
  logic [c_SEL_W-1:0]  w_bus_sel_nxt;
  logic [ADDR_W-1:0]   w_bus_addr_nxt;
  logic [DATA_W-1:0]   w_bus_wdata_nxt;
  logic [DATA_W-1:0]   w_inst_rdata_nxt;
  logic                w_inst_done_nxt;
  logic [DATA_W-1:0]   w_data_rdata_nxt;
  logic                w_data_done_nxt;
  logic                w_err_nxt;

  // Bus cycle termination (real ack or timeout) and the data it returns
  logic                w_tmo_hit;
  logic                w_end;
  logic [DATA_W-1:0]   w_end_rdata;

  assign w_end       = bus_ack_i | w_tmo_hit;
  assign w_end_rdata = bus_ack_i ? bus_rdata_i : DATA_W'(c_ZERO_WORD);

  // Stall requests: held while a request is outstanding and not completing
  assign stallreq_mem_o = data_req_i & ~r_data_done;
  assign stallreq_if_o  = inst_req_i & ~r_inst_done & ~flush_i;

  assign bus_stb_o    = r_bus_stb;
  assign bus_we_o     = r_bus_we;
  assign bus_sel_o    = r_bus_sel;
  assign bus_addr_o   = r_bus_addr;
  assign bus_wdata_o  = r_bus_wdata;
  assign inst_rdata_o = r_inst_rdata;
  assign inst_done_o  = r_inst_done;
  assign data_rdata_o = r_data_rdata;
  assign data_done_o  = r_data_done;

  // Next-state and registered-output logic for the arbiter FSM
  always_comb begin
    w_state_nxt      = r_state;
    w_discard_nxt    = r_discard;
    w_bus_stb_nxt    = r_bus_stb;
    w_bus_we_nxt     = r_bus_we;
    w_bus_sel_nxt    = r_bus_sel;
    w_bus_addr_nxt   = r_bus_addr;
    w_bus_wdata_nxt  = r_bus_wdata;
    w_inst_rdata_nxt = r_inst_rdata;
    w_inst_done_nxt  = 1'b0;
    w_data_rdata_nxt = r_data_rdata;
    w_data_done_nxt  = 1'b0;
    w_err_nxt        = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        // Any ack seen here is stray and ignored. A requester in its done
        // cycle is still holding its old request, so it is not eligible.
        w_discard_nxt = 1'b0;
        if (data_req_i && !r_data_done) begin
          w_state_nxt     = ARB_DATA;
          w_bus_stb_nxt   = 1'b1;
          w_bus_we_nxt    = data_we_i;
          w_bus_sel_nxt   = data_sel_i;
          w_bus_addr_nxt  = data_addr_i;
          w_bus_wdata_nxt = data_wdata_i;
        end else if (inst_req_i && !r_inst_done && !flush_i) begin
          w_state_nxt     = ARB_INST;
          w_bus_stb_nxt   = 1'b1;
          w_bus_we_nxt    = c_WRITE_DISABLE;
          w_bus_sel_nxt   = c_SEL_W'(c_SEL_ALL_ONES);
          w_bus_addr_nxt  = inst_addr_i;
          w_bus_wdata_nxt = DATA_W'(c_ZERO_WORD);
        end
      end

      ARB_DATA: begin
        // Flush is ignored here: a MEM access always completes
        if (w_end) begin
          w_state_nxt     = ARB_IDLE;
          w_bus_stb_nxt   = 1'b0;
          w_data_done_nxt = 1'b1;
          w_err_nxt       = w_tmo_hit & ~bus_ack_i;
          if (r_bus_we == c_WRITE_DISABLE) begin
            w_data_rdata_nxt = w_end_rdata;
          end
        end
      end

      ARB_INST: begin
        if (flush_i) begin
          w_discard_nxt = 1'b1;
        end
        if (w_end) begin
          w_state_nxt   = ARB_IDLE;
          w_bus_stb_nxt = 1'b0;
          w_discard_nxt = 1'b0;
          w_err_nxt     = w_tmo_hit & ~bus_ack_i;
          // A flush arriving in the terminating cycle also discards the word
          if (!r_discard && !flush_i) begin
            w_inst_done_nxt  = 1'b1;
            w_inst_rdata_nxt = w_end_rdata;
          end
        end
      end

      default: begin
        w_state_nxt   = ARB_IDLE;
        w_bus_stb_nxt = 1'b0;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any bus cycle in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_discard    <= 1'b0;
      r_bus_stb    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_sel    <= '0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_inst_rdata <= '0;
      r_inst_done  <= 1'b0;
      r_data_rdata <= '0;
      r_data_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_discard    <= w_discard_nxt;
      r_bus_stb    <= w_bus_stb_nxt;
      r_bus_we     <= w_bus_we_nxt;
      r_bus_sel    <= w_bus_sel_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_wdata  <= w_bus_wdata_nxt;
      r_inst_rdata <= w_inst_rdata_nxt;
      r_inst_done  <= w_inst_done_nxt;
      r_data_rdata <= w_data_rdata_nxt;
      r_data_done  <= w_data_done_nxt;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  logic r_err;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .stb_i (r_bus_stb),
    .ack_i (bus_ack_i),
    .hit_o (w_tmo_hit)
  );

  // Timeout error pulse, aligned with the done pulse of the terminated cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign err_o = r_err;
`else
  // Without the timeout the arbiter waits for ack indefinitely
  logic w_unused_timeout_cfg;

  assign w_tmo_hit            = 1'b0;
  assign err_o                = 1'b0;
  assign w_unused_timeout_cfg = w_err_nxt ^ (TIMEOUT == 0);
`endif

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed, self-checking bench for mem_bus_arbiter. A table of
//               single transactions plus hand-written sequences for priority,
//               stale requests, flush, reset mid-cycle and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_rdata_o;
  logic        inst_done_o;
  logic        stallreq_if_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_done_o;
  logic        stallreq_mem_o;
  logic        flush_i;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req_i     (inst_req_i),
    .inst_addr_i    (inst_addr_i),
    .inst_rdata_o   (inst_rdata_o),
    .inst_done_o    (inst_done_o),
    .stallreq_if_o  (stallreq_if_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_sel_i     (data_sel_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .data_done_o    (data_done_o),
    .stallreq_mem_o (stallreq_mem_o),
    .flush_i        (flush_i),
    .bus_stb_o      (bus_stb_o),
    .bus_we_o       (bus_we_o),
    .bus_sel_o      (bus_sel_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_ack_i      (bus_ack_i),
    .bus_rdata_i    (bus_rdata_i),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;      // stb cycle index (>=1) in which ack is given
    logic [31:0] rdata;      // value driven on bus_rdata_i with ack
    logic [31:0] exp_rdata;  // expected data_rdata_o / inst_rdata_o afterwards
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a table record, checked cycle by cycle
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_data) begin
      data_req_i = 1'b1; data_we_i = v.we; data_sel_i = v.sel;
      data_addr_i = v.addr; data_wdata_i = v.wdata;
    end else begin
      inst_req_i = 1'b1; inst_addr_i = v.addr;
    end
    #1;
    chk({tag, "_stall_req"}, v.is_data ? stallreq_mem_o : stallreq_if_o, 1);
    step();
    chk({tag, "_stb"},  bus_stb_o, 1);
    chk({tag, "_addr"}, bus_addr_o, v.addr);
    chk({tag, "_we"},   bus_we_o, v.is_data ? v.we : 1'b0);
    chk({tag, "_sel"},  bus_sel_o, v.is_data ? v.sel : 4'hF);
    if (v.is_data && v.we) chk({tag, "_wdata"}, bus_wdata_o, v.wdata);
    for (int i = 1; i < v.delay; i++) step();
    chk({tag, "_stb_hold"}, bus_stb_o, 1);
    chk({tag, "_done_early"}, v.is_data ? data_done_o : inst_done_o, 0);
    bus_ack_i = 1'b1; bus_rdata_i = v.rdata;
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0BAD_0BAD;
    chk({tag, "_done"},       v.is_data ? data_done_o : inst_done_o, 1);
    chk({tag, "_other_done"}, v.is_data ? inst_done_o : data_done_o, 0);
    chk({tag, "_stb_drop"},   bus_stb_o, 0);
    chk({tag, "_rdata"},      v.is_data ? data_rdata_o : inst_rdata_o, v.exp_rdata);
    chk({tag, "_stall_done"}, v.is_data ? stallreq_mem_o : stallreq_if_o, 0);
    chk({tag, "_err"},        err_o, 0);
    data_req_i = 1'b0; inst_req_i = 1'b0;
    step();
    chk({tag, "_done_pulse"}, v.is_data ? data_done_o : inst_done_o, 0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; inst_req_i = 0; inst_addr_i = 0; data_req_i = 0; data_we_i = 0;
    data_sel_i = 0; data_addr_i = 0; data_wdata_i = 0; flush_i = 0;
    bus_ack_i = 0; bus_rdata_i = 0;

    //                 data we  sel    addr          wdata          dly rdata          exp_rdata
    tbl[0] = '{1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0,          3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'h1234_5678, 1, 32'h0000_0055, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0,          2, 32'h0000_0013, 32'h0000_0013};
    tbl[3] = '{1'b1, 1'b1, 4'h3, 32'h0000_0204, 32'h0000_CAFE, 1, 32'h7777_7777, 32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b0, 4'h1, 32'h0000_0300, 32'h0,          1, 32'h0000_00A5, 32'h0000_00A5};
    tbl[5] = '{1'b0, 1'b0, 4'hF, 32'h0000_0044, 32'h0,          1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    // Reset state
    repeat (2) step();
    chk("rst_stb", bus_stb_o, 0);
    chk("rst_bus", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
    chk("rst_rdata", {inst_rdata_o, data_rdata_o}, 0);
    chk("rst_done_err", {inst_done_o, data_done_o, err_o}, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Simultaneous requests: store wins, fetch follows after one idle cycle
    inst_req_i = 1; inst_addr_i = 32'h40;
    data_req_i = 1; data_we_i = 1; data_sel_i = 4'hF; data_addr_i = 32'h200; data_wdata_i = 32'h1234_5678;
    step();
    chk("sim_first_addr", bus_addr_o, 32'h200);
    chk("sim_first_we", bus_we_o, 1);
    chk("sim_first_wdata", bus_wdata_o, 32'h1234_5678);
    chk("sim_if_stalled", stallreq_if_o, 1);
    bus_ack_i = 1; step(); bus_ack_i = 0;
    chk("sim_data_done", data_done_o, 1);
    chk("sim_idle_gap", bus_stb_o, 0);
    data_req_i = 0;
    step();
    chk("sim_fetch_stb", bus_stb_o, 1);
    chk("sim_fetch_addr", bus_addr_o, 32'h40);
    chk("sim_fetch_we_sel", {bus_we_o, bus_sel_o}, 5'b0_1111);
    bus_ack_i = 1; bus_rdata_i = 32'h1111_2222; step(); bus_ack_i = 0;
    chk("sim_inst_done", inst_done_o, 1);
    chk("sim_inst_rdata", inst_rdata_o, 32'h1111_2222);
    inst_req_i = 0;
    step();

    // Stale request held through the done cycle must not relaunch
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h300;
    step();
    bus_ack_i = 1; bus_rdata_i = 32'h0BAD_F00D; step(); bus_ack_i = 0;
    chk("stale_done", data_done_o, 1);
    step();
    chk("stale_no_relaunch", bus_stb_o, 0);
    chk("stale_done_once", data_done_o, 0);
    data_req_i = 0;
    step();
    chk("stale_still_idle", bus_stb_o, 0);

    // Flush during a fetch: bus cycle completes, result discarded
    inst_req_i = 1; inst_addr_i = 32'h80;
    step();
    chk("flush_fetch_stb", bus_stb_o, 1);
    flush_i = 1; #1;
    chk("flush_if_no_stall", stallreq_if_o, 0);
    step();
    flush_i = 0;
    chk("flush_stb_kept", bus_stb_o, 1);
    bus_ack_i = 1; bus_rdata_i = 32'hAAAA_5555; step(); bus_ack_i = 0;
    chk("flush_no_done", inst_done_o, 0);
    chk("flush_rdata_kept", inst_rdata_o, 32'h1111_2222);
    chk("flush_stb_drop", bus_stb_o, 0);
    inst_req_i = 0;
    step();
    chk("flush_idle", bus_stb_o, 0);
    v = '{1'b0, 1'b0, 4'hF, 32'h84, 32'h0, 1, 32'h0000_600D, 32'h0000_600D};
    run_vec(v, 6);

    // Flush during a store has no effect
    data_req_i = 1; data_we_i = 1; data_sel_i = 4'hF; data_addr_i = 32'h210; data_wdata_i = 32'h77;
    flush_i = 1; #1;
    chk("dflush_stall", stallreq_mem_o, 1);
    step();
    chk("dflush_stb", bus_stb_o, 1);
    bus_ack_i = 1; step(); bus_ack_i = 0;
    chk("dflush_done", data_done_o, 1);
    chk("dflush_rdata_kept", data_rdata_o, 32'h0BAD_F00D);
    flush_i = 0; data_req_i = 0;
    step();

    // Reset mid-cycle, then a stray ack
    data_req_i = 1; data_we_i = 0; data_sel_i = 4'hF; data_addr_i = 32'h400;
    step();
    chk("rmid_stb", bus_stb_o, 1);
    rst = 1;
    step();
    chk("rmid_bus_clear", {bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
    chk("rmid_rdata_clear", {inst_rdata_o, data_rdata_o}, 0);
    rst = 0; data_req_i = 0;
    bus_ack_i = 1; bus_rdata_i = 32'hFEED_FACE; step(); bus_ack_i = 0;
    chk("rmid_no_done", {data_done_o, inst_done_o}, 0);
    chk("rmid_stb_low", bus_stb_o, 0);
    step();
    chk("rmid_rdata_zero", data_rdata_o, 0);

`ifdef MEM_BUS_TIMEOUT_EN
    // Ack timeout with TIMEOUT = 4
    v = '{1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 1, 32'h0000_5A5A, 32'h0000_5A5A};
    run_vec(v, 7);
    data_req_i = 1; data_we_i = 0; data_sel_i = 4'hF; data_addr_i = 32'h504;
    step();
    chk("tmo_stb", bus_stb_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("tmo_wait%0d", i), {data_done_o, err_o, bus_stb_o}, 3'b001);
    end
    step();
    chk("tmo_done_err", {data_done_o, err_o}, 2'b11);
    chk("tmo_rdata_zero", data_rdata_o, 0);
    chk("tmo_stb_drop", bus_stb_o, 0);
    data_req_i = 0;
    step();
    chk("tmo_err_pulse", err_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_bus_arbiter
`default_nettype wire
